// File: rtl/capture_sequencer_if.sv
// ============================================================================
// Module      : capture_sequencer_if
// Description : Control and ring-buffer bus between the capture sequencer and
//               its surroundings. The master drives the capture requests and
//               observes the write port; the slave is the sequencer itself.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface capture_sequencer_if #(
    parameter int SIZE = 12
);
    // Requests and configuration towards the sequencer
    logic            arm;
    logic            trigger;
    logic            sample_valid;
    logic [SIZE-1:0] pre_samples;
    logic [SIZE-1:0] post_samples;
    logic            ack;

    // Ring-buffer write port and capture results
    logic            wr_en;
    logic [SIZE-1:0] wr_addr;
    logic [SIZE-1:0] trig_addr;
    logic [SIZE-1:0] start_addr;
    logic            busy;
    logic            done;
    logic            short_pre;
    logic            cfg_err;
    logic [2:0]      state;

    modport master (
        output arm, trigger, sample_valid, pre_samples, post_samples, ack,
        input  wr_en, wr_addr, trig_addr, start_addr, busy, done,
               short_pre, cfg_err, state
    );

    modport slave (
        input  arm, trigger, sample_valid, pre_samples, post_samples, ack,
        output wr_en, wr_addr, trig_addr, start_addr, busy, done,
               short_pre, cfg_err, state
    );
endinterface

`default_nettype wire

// File: rtl/capture_sequencer.sv
// ============================================================================
// Module      : capture_sequencer
// Description : Pre/post-trigger capture controller for an ADC ring buffer.
//               Fills a pre-trigger window, waits for a trigger rising edge,
//               records the post-trigger window and reports where the
//               capture starts and where the trigger landed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_sequencer #(
    parameter int SIZE = 12
) (
    input  wire                 adc_fast_clk,
    input  wire                 reset,
    capture_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_PREFILL = 3'b001,
        ST_ARMED   = 3'b010,
        ST_POST    = 3'b011,
        ST_DONE    = 3'b100
    } state_t;

    // Ring depth expressed in the widened sum domain used for the config check
    localparam logic [SIZE:0]   c_depth = {1'b1, {SIZE{1'b0}}};
    localparam logic [SIZE-1:0] c_one   = {{(SIZE-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_trig_q;
    logic [SIZE-1:0] r_wr_addr;
    logic [SIZE-1:0] r_trig_addr;
    logic [SIZE-1:0] r_start_addr;
    logic [SIZE-1:0] r_pre;
    logic [SIZE-1:0] r_post;
    logic [SIZE-1:0] r_pre_cnt;
    logic [SIZE-1:0] r_post_cnt;
    logic            r_short_pre;
    logic            r_cfg_err;

    logic            w_edge;
    logic            w_capturing;
    logic            w_wr_en;
    logic [SIZE-1:0] w_wr_inc;
    logic [SIZE-1:0] w_next_addr;
    logic [SIZE-1:0] w_pre_now;
    logic [SIZE-1:0] w_pre_eff;
    logic [SIZE:0]   w_sum;
    logic            w_cfg_bad;
    logic            w_pre_done;
    logic            w_post_done;
    logic            w_accept;
    logic            w_reject;
    logic            w_trig_short;
    logic            w_trig_full;

    // Trigger event is a rising edge against the previous-cycle level
    assign w_edge      = bus.trigger & ~r_trig_q;

    // Writes follow sample_valid with no added latency while capturing; the
    // reset term keeps the reset cycle itself free of writes
    assign w_capturing = (r_state == ST_PREFILL) || (r_state == ST_ARMED) ||
                         (r_state == ST_POST);
    assign w_wr_en     = ~reset & bus.sample_valid & w_capturing;
    assign w_wr_inc    = {{(SIZE-1){1'b0}}, w_wr_en};

    // First post-trigger sample is whatever address gets written next
    assign w_next_addr = r_wr_addr + w_wr_inc;
    assign w_pre_now   = r_pre_cnt + w_wr_inc;
    assign w_pre_eff   = w_trig_short ? w_pre_now : r_pre;

    // Window request must fit in the ring; exactly full is allowed
    assign w_sum       = {1'b0, bus.pre_samples} + {1'b0, bus.post_samples};
    assign w_cfg_bad   = (w_sum > c_depth);

    assign w_pre_done  = (r_pre == '0) ||
                         (w_wr_en && ((r_pre_cnt + c_one) == r_pre));
    assign w_post_done = w_wr_en && ((r_post_cnt + c_one) == r_post);

    // State register
    always_ff @(posedge adc_fast_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and capture-event strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_trig_short = 1'b0;
        w_trig_full  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.arm) begin
                    if (w_cfg_bad) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_PREFILL;
                    end
                end
            end
            ST_PREFILL: begin
                // An edge landing on the completing write counts as a full window
                if (w_edge && !w_pre_done) begin
                    w_trig_short = 1'b1;
                    w_state_nxt  = (r_post == '0) ? ST_DONE : ST_POST;
                end else if (w_edge) begin
                    w_trig_full  = 1'b1;
                    w_state_nxt  = (r_post == '0) ? ST_DONE : ST_POST;
                end else if (w_pre_done) begin
                    w_state_nxt  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_edge) begin
                    w_trig_full = 1'b1;
                    w_state_nxt = (r_post == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (w_post_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address, counter and capture-result registers
    always_ff @(posedge adc_fast_clk) begin
        if (reset) begin
            r_trig_q     <= 1'b1;
            r_wr_addr    <= '0;
            r_trig_addr  <= '0;
            r_start_addr <= '0;
            r_pre        <= '0;
            r_post       <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_short_pre  <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_trig_q <= bus.trigger;
            if (w_accept) begin
                r_pre       <= bus.pre_samples;
                r_post      <= bus.post_samples;
                r_wr_addr   <= '0;
                r_pre_cnt   <= '0;
                r_post_cnt  <= '0;
                r_cfg_err   <= 1'b0;
                r_short_pre <= 1'b0;
            end else if (w_reject) begin
                r_cfg_err   <= 1'b1;
            end else if (w_wr_en) begin
                r_wr_addr <= r_wr_addr + c_one;
                if (r_state == ST_PREFILL) begin
                    r_pre_cnt <= r_pre_cnt + c_one;
                end
                if (r_state == ST_POST) begin
                    r_post_cnt <= r_post_cnt + c_one;
                end
            end
            // Capture geometry is fixed at the trigger and held through DONE
            if (w_trig_short || w_trig_full) begin
                r_trig_addr  <= w_next_addr;
                r_start_addr <= w_next_addr - w_pre_eff;
                r_short_pre  <= w_trig_short;
                r_post_cnt   <= '0;
            end
        end
    end

    assign bus.wr_en      = w_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.trig_addr  = r_trig_addr;
    assign bus.start_addr = r_start_addr;
    assign bus.busy       = w_capturing;
    assign bus.done       = (r_state == ST_DONE);
    assign bus.short_pre  = r_short_pre;
    assign bus.cfg_err    = r_cfg_err;
    assign bus.state      = r_state;

endmodule

`default_nettype wire

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter SIZE, default 12, ring-buffer address width (depth 2^SIZE samples).
REQ-002 SHALL have port adc_fast_clk  in  1  sole clock.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port arm  in  1  single-cycle request to start a capture.
REQ-005 SHALL have port trigger  in  1  level trigger, synchronous to adc_fast_clk; rising edge is the event.
REQ-006 SHALL have port sample_valid  in  1  one-cycle strobe per deserialized ADC word.
REQ-007 SHALL have port pre_samples  in  SIZE  requested pre-trigger depth.
REQ-008 SHALL have port post_samples  in  SIZE  requested post-trigger depth.
REQ-009 SHALL have port ack  in  1  consumer has read the capture.
REQ-010 SHALL have port wr_en  out  1  ring-buffer write strobe.
REQ-011 SHALL have port wr_addr  out  SIZE  ring-buffer write address.
REQ-012 SHALL have port trig_addr  out  SIZE  address of first post-trigger sample.
REQ-013 SHALL have port start_addr  out  SIZE  address of oldest valid sample.
REQ-014 SHALL have ports busy, done, short_pre, cfg_err  out  1 each; state  out  3 (debug).

Function
REQ-015 SHALL implement states IDLE=000, PREFILL=001, ARMED=010, POST=011, DONE=100, all registered.
REQ-016 SHALL register trigger into trig_q; edge = trigger & ~trig_q.
REQ-017 SHALL drive wr_en = sample_valid & (state in PREFILL/ARMED/POST), combinationally, zero added latency; wr_addr is the registered current address.
REQ-018 SHALL increment wr_addr modulo 2^SIZE on every cycle wr_en=1 (4095->0 wrap at SIZE=12).
REQ-019 IDLE: on arm, latch pre_samples/post_samples; if pre+post (SIZE+1-bit sum) > 2^SIZE set cfg_err=1 and stay IDLE; else clear cfg_err/short_pre, wr_addr=0, pre_cnt=0, go PREFILL.
REQ-020 PREFILL: pre_cnt increments per write; when the increment reaches latched pre (or pre=0 on entry) go ARMED.
REQ-021 PREFILL edge before pre depth reached: trig_addr=address of the next write (wr_addr+wr_en), pre_eff=pre_cnt after this cycle's write, short_pre=1, go POST.
REQ-022 Edge in same cycle that completes prefill: treated as ARMED trigger, short_pre=0.
REQ-023 ARMED: writes continue with wrap; on edge trig_addr=wr_addr+wr_en, pre_eff=latched pre, post_cnt=0, go POST.
REQ-024 POST: post_cnt increments per write; when it equals latched post go DONE; post=0 -> DONE the cycle after the edge with no post writes.
REQ-025 Edges in POST/DONE/IDLE SHALL be ignored; arm outside IDLE ignored.
REQ-026 DONE: wr_en=0, done=1, start_addr=(trig_addr-pre_eff) mod 2^SIZE held stable; ack -> IDLE with done=0 next cycle; arm+ack same cycle: ack only.
REQ-027 busy SHALL be 1 in PREFILL, ARMED, POST; 0 otherwise.

Reset
REQ-028 reset SHALL force IDLE next edge from any state: wr_addr, trig_addr, start_addr, counters, done, busy, short_pre, cfg_err = 0; trig_q = 1 (high trigger at release is not an edge).
REQ-029 No write SHALL occur in the reset cycle or the cycle after release.

Verification (SIZE=12, sample_valid=1 every cycle unless stated)
REQ-030 pre=4, post=3, edge after 10 writes -> trig_addr=10, writes 0..12, done after 13th write, start_addr=6, short_pre=0.
REQ-031 pre=4, post=3, edge after 2 writes -> short_pre=1, trig_addr=2, start_addr=0, done after 5 writes.
REQ-032 pre=4, post=8, edge after 4100 writes -> wr_addr wraps 4095->0, trig_addr=4, start_addr=0, final wr_addr=12.
REQ-033 pre=3000, post=2000, arm -> cfg_err=1, state=IDLE, wr_en never 1; re-arm with pre=4 clears cfg_err.
REQ-034 reset asserted mid-POST -> next cycle state=000, wr_en=0, done=0, busy=0, wr_addr=0.
REQ-035 post=0, sample_valid every 2nd cycle, edge in ARMED -> DONE next cycle, no post writes, start_addr=trig_addr-pre; arm+ack in DONE -> IDLE, no new capture.
